// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32 funct3 size/sign codes used by loads and stores
//   - response error encodings returned on resp_err
//   - LSU state encoding
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load formatting: picks the addressed byte/halfword out of a 32-bit memory
// word and sign- or zero-extends it. Purely combinational.
//   word_i   : raw memory word
//   offset_i : byte offset within the word (addr[1:0])
//   funct3_i : RV32 load size/sign code
//   rdata_o  : formatted 32-bit result
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_o = {24'h000000, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_o = {16'h0000, half_sel};
      default: rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the core memory stage and BRAM port B.
//   clk, reset (async, active low)
//   req_*   : one load/store request, valid/ready handshake
//   resp_*  : formatted load data and error code, valid/ready handshake
//   enaB, weB, addrB, dinB : BRAM port B drive, combinational from the request
//                            during an accepting IDLE cycle
//   doutB   : BRAM read data, one cycle after enaB
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COL    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  enaB,
  output logic [NUM_COL-1:0]    weB,
  output logic [ADDR_WIDTH-1:0] addrB,
  output logic [DATA_WIDTH-1:0] dinB,
  input  logic [DATA_WIDTH-1:0] doutB
);

  lsu_state_e  state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [1:0]  resp_err_q;

  logic        is_b, is_h, is_w;
  logic        f3_bad, misalign, out_range;
  logic [1:0]  err_d;
  logic [3:0]  be_d;
  logic [31:0] din_d;
  logic        accept, legal;
  logic [31:0] load_data;

  // Request decode and legality check
  always_comb begin
    is_b = (req_funct3[1:0] == 2'b00);
    is_h = (req_funct3[1:0] == 2'b01);
    is_w = (req_funct3[1:0] == 2'b10);

    if (req_we)
      f3_bad = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W));
    else
      f3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);

    misalign  = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
    out_range = |req_addr[31:ADDR_WIDTH+2];

    if (f3_bad)         err_d = ERR_FUNCT3;
    else if (misalign)  err_d = ERR_MISALIGN;
    else if (out_range) err_d = ERR_RANGE;
    else                err_d = ERR_OK;

    // Store lane placement: narrow data is replicated so any lane sees it
    be_d  = 4'b0000;
    din_d = req_wdata;
    if (is_b) begin
      be_d  = 4'b0001 << req_addr[1:0];
      din_d = {4{req_wdata[7:0]}};
    end else if (is_h) begin
      be_d  = req_addr[1] ? 4'b1100 : 4'b0011;
      din_d = {2{req_wdata[15:0]}};
    end else if (is_w) begin
      be_d  = 4'b1111;
    end
  end

  // reset gates acceptance so port B stays quiet while reset is asserted
  assign accept = req_valid && (state_q == ST_IDLE) && reset;
  assign legal  = (err_d == ERR_OK);

  assign req_ready = (state_q == ST_IDLE);
  assign enaB      = accept && legal;
  assign weB       = (accept && legal && req_we) ? NUM_COL'(be_d) : '0;
  assign addrB     = req_addr[ADDR_WIDTH+1:2];
  assign dinB      = DATA_WIDTH'(din_d);

  lsu_load_align u_align (
    .word_i   (doutB),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .rdata_o  (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= ERR_OK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (!legal || req_we) begin
              // errors and stores answer immediately; memory was touched
              // (or skipped) on this same edge
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0;
              resp_err_q   <= err_d;
            end else begin
              state_q <= ST_RD_WAIT;
              off_q   <= req_addr[1:0];
              f3_q    <= req_funct3;
            end
          end
        end
        ST_RD_WAIT: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
          resp_err_q   <= ERR_OK;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        enaB;
  logic [3:0]  weB;
  logic [12:0] addrB;
  logic [31:0] dinB;
  logic [31:0] doutB;

  int vectors = 0;
  int miscompares = 0;

  mem_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .enaB(enaB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB)
  );

  always #5 clk = ~clk;

  // BRAM port B stand-in
  logic [31:0] bram [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) bram[i] = 32'h0;
    doutB = 32'h0;
  end
  always @(posedge clk) begin
    if (enaB) begin
      for (int l = 0; l < 4; l++)
        if (weB[l]) bram[addrB][8*l +: 8] <= dinB[8*l +: 8];
      doutB <= bram[addrB];
    end
  end

  // Reference model: flat byte-addressed memory
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] ref_err(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr);
    int sz;
    if (we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7}))
      return 2'b11;
    sz = size_of(f3);
    if ((addr % 32'(sz)) != 0) return 2'b01;
    if (addr >= 32'h0000_8000) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    logic [31:0] v;
    sz = size_of(f3);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(get_byte(addr + 32'(i))) << (8*i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall, input string name);
    logic [1:0]  e_err;
    logic        e_en;
    logic [3:0]  e_we;
    logic [31:0] e_din, e_rd;
    int          e_lat, lat, sz;
    e_err = ref_err(we, f3, addr);
    e_en  = (e_err == 2'b00);
    sz    = size_of(f3);
    e_we  = 4'b0000;
    e_din = 32'h0;
    e_rd  = 32'h0;
    if (e_en && we) begin
      for (int i = 0; i < sz; i++) e_we[(int'(addr[1:0]) + i)] = 1'b1;
      for (int l = 0; l < 4; l++) e_din[8*l +: 8] = wd[8*(l % sz) +: 8];
    end
    if (e_en && !we) e_rd = ref_load(f3, addr);
    e_lat = (e_en && !we) ? 2 : 1;

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL %s req_ready got %b want 1", name, req_ready); end
    vectors++;
    if (enaB !== e_en) begin miscompares++;
      $display("FAIL %s enaB got %b want %b", name, enaB, e_en); end
    vectors++;
    if (weB !== e_we) begin miscompares++;
      $display("FAIL %s weB got %b want %b", name, weB, e_we); end
    if (e_en) begin
      vectors++;
      if (addrB !== addr[14:2]) begin miscompares++;
        $display("FAIL %s addrB got %h want %h", name, addrB, addr[14:2]); end
      if (we) begin
        vectors++;
        if (dinB !== e_din) begin miscompares++;
          $display("FAIL %s dinB got %h want %h", name, dinB, e_din); end
      end
    end

    @(posedge clk); #1;
    if (e_en && we)
      for (int i = 0; i < sz; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
    if (stall == 0) req_valid = 1'b0;

    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      vectors++;
      if (enaB !== 1'b0 || req_ready !== 1'b0) begin miscompares++;
        $display("FAIL %s busy enaB/req_ready got %b/%b want 0/0", name, enaB, req_ready); end
    end
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s timeout resp_valid got %b want 1", name, resp_valid);
      req_valid = 1'b0; reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      return;
    end
    vectors++;
    if (lat != e_lat) begin miscompares++;
      $display("FAIL %s latency got %0d want %0d", name, lat, e_lat); end
    vectors++;
    if (resp_err !== e_err) begin miscompares++;
      $display("FAIL %s resp_err got %b want %b", name, resp_err, e_err); end
    vectors++;
    if (resp_rdata !== e_rd) begin miscompares++;
      $display("FAIL %s resp_rdata got %h want %h", name, resp_rdata, e_rd); end

    for (int i = 0; i < stall; i++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== e_rd || resp_err !== e_err ||
          req_ready !== 1'b0 || enaB !== 1'b0 || weB !== 4'b0000) begin
        miscompares++;
        $display("FAIL %s stall%0d valid/rdata/err/rdy/ena got %b/%h/%b/%b/%b want 1/%h/%b/0/0",
                 name, i, resp_valid, resp_rdata, resp_err, req_ready, enaB, e_rd, e_err);
      end
      @(negedge clk);
    end

    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++;
      $display("FAIL %s handshake valid/ready got %b/%b want 0/1", name, resp_valid, req_ready); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    #12;
    vectors++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 2'b00 ||
        enaB !== 1'b0 || weB !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset valid/rdata/err/ena/we got %b/%h/%b/%b/%b want 0/0/00/0/0",
               resp_valid, resp_rdata, resp_err, enaB, weB);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_directed();
    do_req(1'b1, 3'b010, 32'h10,  32'hCAFE_F00D, 0, "sw_0x10");
    do_req(1'b1, 3'b000, 32'h13,  32'h0000_00A5, 0, "sb_0x13");
    do_req(1'b0, 3'b000, 32'h13,  32'h0,         0, "lb_0x13");
    do_req(1'b0, 3'b100, 32'h13,  32'h0,         0, "lbu_0x13");
    do_req(1'b1, 3'b001, 32'h22,  32'h0000_8001, 0, "sh_0x22");
    do_req(1'b0, 3'b001, 32'h22,  32'h0,         0, "lh_0x22");
    do_req(1'b0, 3'b101, 32'h22,  32'h0,         0, "lhu_0x22");
    do_req(1'b1, 3'b010, 32'hFFC, 32'h1234_5678, 0, "sw_mmio");
    do_req(1'b0, 3'b010, 32'hFFC, 32'h0,         0, "lw_mmio");
    do_req(1'b1, 3'b010, 32'h7FFC, 32'hA5A5_0F0F, 0, "sw_top");
    do_req(1'b0, 3'b010, 32'h7FFC, 32'h0,        0, "lw_top");
  endtask

  task automatic test_errors();
    do_req(1'b0, 3'b010, 32'h06,   32'h0, 0, "lw_misalign");
    do_req(1'b0, 3'b010, 32'h8000, 32'h0, 0, "lw_range");
    do_req(1'b0, 3'b011, 32'h10,   32'h0, 0, "ld_f3_011");
    do_req(1'b1, 3'b100, 32'h10,   32'hFFFF_FFFF, 0, "st_f3_100");
    do_req(1'b1, 3'b001, 32'h8001, 32'hFFFF_FFFF, 0, "sh_mis_over_range");
    do_req(1'b0, 3'b111, 32'h8003, 32'h0, 0, "f3_over_all");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_after_errors");
  endtask

  task automatic test_backpressure();
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, "lw_backpressure");
    do_req(1'b1, 3'b000, 32'h40, 32'h0000_0077, 5, "sb_backpressure");
    do_req(1'b0, 3'b000, 32'h40, 32'h0, 0, "lb_after_bp");
  endtask

  task automatic test_reset_in_rd_wait();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || enaB !== 1'b0) begin miscompares++;
      $display("FAIL rst_rdwait valid/ready/ena got %b/%b/%b want 0/1/0",
               resp_valid, req_ready, enaB); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_rdwait_after valid got %b want 0", resp_valid); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_after_reset");
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          r;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      r  = int'($urandom % 10);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'h7FF8 + 32'($urandom_range(0, 15));
      else             addr = 32'($urandom_range(0, 63));
      wd = $urandom;
      do_req(we, f3, addr, wd, int'($urandom % 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_in_rd_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
